// File: rtl/adc_capture_multi.sv
`default_nettype none
// ============================================================================
//  Module   : adc_capture_multi
//  Purpose  : Multi-channel ADCS7476-style serial capture with shared clock and
//             chip select, optional averaging and valid/ready result output.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_capture_multi #(
    parameter int CHANNELS      = 1,
    parameter int ADC_BITS      = 12,
    parameter int FRAME_BITS    = 16,
    parameter int LEAD_ZEROS    = 4,
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 20000,
    parameter int QUIET         = 2,
    parameter int AVG_LOG2      = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    output logic                         adc_clk,
    output logic                         adc_cs,
    input  logic [CHANNELS-1:0]          adc_sd,
    output logic [CHANNELS*ADC_BITS-1:0] data,
    output logic                         valid,
    input  logic                         ready,
    output logic                         overrun,
    output logic                         busy
);

    localparam int c_TICK_W   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int c_HOLD_CYC = QUIET * CLK_DIV;
    localparam int c_CNT_MAX  = (c_HOLD_CYC > CLK_DIV) ? c_HOLD_CYC : CLK_DIV;
    localparam int c_CNT_W    = $clog2(c_CNT_MAX + 1);
    localparam int c_BIT_W    = $clog2(FRAME_BITS + 1);
    localparam int c_AVG_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int c_ACC_W    = ADC_BITS + AVG_LOG2;
    localparam int c_CONV_CYC = CLK_DIV * (1 + 2 * FRAME_BITS);

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(SAMPLE_PERIOD - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
    localparam logic [c_CNT_W-1:0]  c_DIV_LAST  = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0]  c_HOLD_LAST = c_CNT_W'(c_HOLD_CYC - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(FRAME_BITS - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_ONE   = c_BIT_W'(1);
    localparam logic [c_AVG_W-1:0]  c_AVG_LAST  = c_AVG_W'((1 << AVG_LOG2) - 1);
    localparam logic [c_AVG_W-1:0]  c_AVG_ONE   = c_AVG_W'(1);

    localparam bit c_CFG_OK = (CHANNELS >= 1) && (CHANNELS <= 8) && (ADC_BITS >= 1) &&
                              (CLK_DIV >= 1) && (LEAD_ZEROS + ADC_BITS <= FRAME_BITS) &&
                              (SAMPLE_PERIOD > c_CONV_CYC + c_HOLD_CYC + 1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_CS_SETUP = 3'd1;
    localparam logic [2:0] c_SHIFT    = 3'd2;
    localparam logic [2:0] c_CS_HOLD  = 3'd3;
    localparam logic [2:0] c_COMMIT   = 3'd4;

    logic [c_TICK_W-1:0] r_tick;
    logic [2:0]          r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic                r_half, w_half_nxt;
    logic [c_BIT_W-1:0]  r_bit, w_bit_nxt;
    logic [c_AVG_W-1:0]  r_avg;
    logic                r_adc_clk, r_adc_cs, r_busy, r_valid, r_overrun;
    logic                w_start, w_sample, w_capture, w_commit, w_result;

    // Sample-period tick; holds its value while enable is low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tick <= '0;
        end else if (enable) begin
            r_tick <= (r_tick == c_TICK_LAST) ? '0 : r_tick + c_TICK_ONE;
        end
    end

    assign w_start = enable && (r_tick == c_TICK_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_half  <= 1'b0;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_half  <= w_half_nxt;
            r_bit   <= w_bit_nxt;
        end
    end

    // r_half: 0 = falling half (adc_clk low), 1 = rising half (adc_clk high).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_CNT_ONE;
        w_half_nxt  = r_half;
        w_bit_nxt   = r_bit;
        w_sample    = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_cnt_nxt = '0;
                if (w_start) begin
                    w_state_nxt = c_CS_SETUP;
                    w_half_nxt  = 1'b0;
                    w_bit_nxt   = '0;
                end
            end
            c_CS_SETUP: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_state_nxt = c_SHIFT;
                    w_cnt_nxt   = '0;
                    w_half_nxt  = 1'b0;
                    w_bit_nxt   = '0;
                end
            end
            c_SHIFT: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_cnt_nxt = '0;
                    if (!r_half) begin
                        w_half_nxt = 1'b1;
                        w_sample   = 1'b1;
                    end else begin
                        w_half_nxt = 1'b0;
                        if (r_bit == c_BIT_LAST) begin
                            w_state_nxt = (c_HOLD_CYC == 0) ? c_COMMIT : c_CS_HOLD;
                        end else begin
                            w_bit_nxt = r_bit + c_BIT_ONE;
                        end
                    end
                end
            end
            c_CS_HOLD: begin
                if (r_cnt == c_HOLD_LAST) begin
                    w_state_nxt = c_COMMIT;
                    w_cnt_nxt   = '0;
                end
            end
            c_COMMIT: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_capture = w_sample && (int'(r_bit) >= LEAD_ZEROS) &&
                       (int'(r_bit) < LEAD_ZEROS + ADC_BITS);
    assign w_commit  = (r_state == c_COMMIT);
    assign w_result  = w_commit && (r_avg == c_AVG_LAST);

    // Pin drivers are registered from the next state so they never glitch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_adc_cs  <= 1'b1;
            r_adc_clk <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_adc_cs  <= !((w_state_nxt == c_CS_SETUP) || (w_state_nxt == c_SHIFT));
            r_adc_clk <= !((w_state_nxt == c_SHIFT) && !w_half_nxt);
            r_busy    <= (w_state_nxt == c_CS_SETUP) || (w_state_nxt == c_SHIFT) ||
                         (w_state_nxt == c_CS_HOLD);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_avg <= '0;
        end else if (w_commit) begin
            r_avg <= (r_avg == c_AVG_LAST) ? '0 : r_avg + c_AVG_ONE;
        end
    end

    // A fresh result always wins; overrun flags the lost unconsumed one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_result && r_valid && !ready;
            if (w_result) begin
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [ADC_BITS-1:0] r_shift;
        logic [ADC_BITS-1:0] w_shift_nxt;
        logic [c_ACC_W-1:0]  r_acc;
        logic [c_ACC_W-1:0]  w_sum;
        logic [ADC_BITS-1:0] r_word;

        if (ADC_BITS > 1) begin : g_shift_wide
            assign w_shift_nxt = {r_shift[ADC_BITS-2:0], adc_sd[i]};
        end else begin : g_shift_narrow
            assign w_shift_nxt = adc_sd[i];
        end

        assign w_sum = r_acc + c_ACC_W'(r_shift);

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_shift <= '0;
                r_acc   <= '0;
                r_word  <= '0;
            end else begin
                if (w_capture) begin
                    r_shift <= w_shift_nxt;
                end
                if (w_commit) begin
                    if (w_result) begin
                        r_acc  <= '0;
                        r_word <= w_sum[c_ACC_W-1 -: ADC_BITS];
                    end else begin
                        r_acc  <= w_sum;
                    end
                end
            end
        end

        assign data[i*ADC_BITS +: ADC_BITS] = r_word;
    end

    assign adc_clk = r_adc_clk;
    assign adc_cs  = r_adc_cs;
    assign busy    = r_busy;
    assign valid   = r_valid;
    assign overrun = r_overrun;

    a_cfg_ok: assert property (@(posedge clk) c_CFG_OK)
        else $error("adc_capture_multi: sample period too short or frame layout invalid");

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_capture_multi
//  Purpose  : Directed self-checking bench with serial converter models.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adc_capture_multi;

    localparam int SP = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Instance A: three channels, no averaging
    logic        a_reset = 1'b0, a_enable = 1'b0, a_ready = 1'b0;
    logic        a_adc_clk, a_adc_cs, a_valid, a_overrun, a_busy;
    logic [2:0]  a_sd = 3'b000;
    logic [35:0] a_data;

    adc_capture_multi #(
        .CHANNELS(3), .ADC_BITS(12), .FRAME_BITS(16), .LEAD_ZEROS(4),
        .CLK_DIV(4), .SAMPLE_PERIOD(SP), .QUIET(2), .AVG_LOG2(0)
    ) dut_a (
        .clk(clk), .reset(a_reset), .enable(a_enable), .adc_clk(a_adc_clk),
        .adc_cs(a_adc_cs), .adc_sd(a_sd), .data(a_data), .valid(a_valid),
        .ready(a_ready), .overrun(a_overrun), .busy(a_busy)
    );

    // Instance B: one channel, four-sample averaging
    logic        b_reset = 1'b0, b_enable = 1'b0, b_ready = 1'b0;
    logic        b_adc_clk, b_adc_cs, b_valid, b_overrun, b_busy;
    logic        b_sd = 1'b0;
    logic [11:0] b_data;

    adc_capture_multi #(
        .CHANNELS(1), .ADC_BITS(12), .FRAME_BITS(16), .LEAD_ZEROS(4),
        .CLK_DIV(4), .SAMPLE_PERIOD(SP), .QUIET(2), .AVG_LOG2(2)
    ) dut_b (
        .clk(clk), .reset(b_reset), .enable(b_enable), .adc_clk(b_adc_clk),
        .adc_cs(b_adc_cs), .adc_sd(b_sd), .data(b_data), .valid(b_valid),
        .ready(b_ready), .overrun(b_overrun), .busy(b_busy)
    );

    // Converter models: new bit on each adc_clk fall, 4 zeros then MSB first
    logic [11:0] a_val [3];
    logic [15:0] a_word;
    int          a_k = 0, a_pulses = 0, a_cs_falls = 0;

    always @(negedge a_adc_cs) begin
        a_k = 0;
        a_cs_falls++;
    end

    always @(negedge a_adc_clk) begin
        if (!a_adc_cs) begin
            a_pulses++;
            for (int c = 0; c < 3; c++) begin
                a_word = {4'b0000, a_val[c]};
                if (a_k < 16) a_sd[c] = a_word[15 - a_k];
            end
            a_k++;
        end
    end

    logic [11:0] b_seq [4];
    logic [15:0] b_word;
    int          b_idx = 0, b_k = 0, b_cs_falls = 0;

    always @(negedge b_adc_cs) begin
        b_k = 0;
        b_cs_falls++;
    end

    always @(posedge b_adc_cs) begin
        if (b_reset && b_idx < 3) b_idx++;
    end

    always @(negedge b_adc_clk) begin
        if (!b_adc_cs) begin
            b_word = {4'b0000, b_seq[b_idx]};
            if (b_k < 16) b_sd = b_word[15 - b_k];
            b_k++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a_cs(input logic lvl, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (a_adc_cs === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_a_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (a_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    int t_rel;

    task automatic test_reset();
        a_reset = 1'b0; a_enable = 1'b1; a_ready = 1'b0;
        a_val[0] = 12'h000; a_val[1] = 12'h000; a_val[2] = 12'h000;
        repeat (3) step();
        checks++;
        if ({a_adc_cs, a_adc_clk, a_valid, a_overrun, a_busy} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_ctrl: cs/clk/valid/overrun/busy got %b want 11000",
                     {a_adc_cs, a_adc_clk, a_valid, a_overrun, a_busy});
        end
        checks++;
        if (a_data !== 36'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", a_data);
        end
        a_reset = 1'b1;
        t_rel = cyc;
    endtask

    task automatic test_nominal();
        bit ok;
        int t0;
        a_val[0] = 12'hABC;
        wait_a_cs(1'b0, SP + 10, ok);
        t0 = cyc;
        a_pulses = 0;
        checks++;
        if (!ok || (t0 - t_rel) != SP) begin
            errors++;
            $display("FAIL first_start: cs fell after %0d cycles (ok=%0d) want %0d", t0 - t_rel, ok, SP);
        end
        checks++;
        if (a_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_frame: got %b want 1", a_busy);
        end
        wait_a_cs(1'b1, 200, ok);
        checks++;
        if (!ok || (cyc - t0) != 132) begin
            errors++;
            $display("FAIL cs_width: got %0d cycles want 132", cyc - t0);
        end
        checks++;
        if (a_pulses != 16) begin
            errors++;
            $display("FAIL clk_pulses: got %0d want 16", a_pulses);
        end
        wait_a_valid(50, ok);
        checks++;
        if (!ok || (cyc - t0) != 141) begin
            errors++;
            $display("FAIL latency: got %0d cycles want 141", cyc - t0);
        end
        checks++;
        if (a_data !== 36'h000000ABC) begin
            errors++;
            $display("FAIL nominal_data: got %h want 000000abc", a_data);
        end
        repeat (3) step();
        checks++;
        if (a_valid !== 1'b1 || a_data !== 36'h000000ABC) begin
            errors++;
            $display("FAIL valid_hold: valid %b data %h want 1 000000abc", a_valid, a_data);
        end
        a_ready = 1'b1;
        step();
        a_ready = 1'b0;
        checks++;
        if (a_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_clear: got %b want 0", a_valid);
        end
    endtask

    task automatic test_packing();
        bit ok;
        a_val[0] = 12'h001; a_val[1] = 12'h800; a_val[2] = 12'hFFF;
        wait_a_cs(1'b0, SP + 10, ok);
        wait_a_valid(200, ok);
        checks++;
        if (!ok || a_data !== 36'hFFF800001) begin
            errors++;
            $display("FAIL packing: got %h (ok=%0d) want fff800001", a_data, ok);
        end
        a_ready = 1'b1;
        step();
        a_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int ov = 0;
        logic [35:0] ov_data = '0;
        logic ov_valid = 1'b0;
        a_val[0] = 12'h111; a_val[1] = 12'h111; a_val[2] = 12'h111;
        wait_a_cs(1'b0, SP + 10, ok);
        wait_a_valid(200, ok);
        checks++;
        if (!ok || a_data !== 36'h111111111) begin
            errors++;
            $display("FAIL bp_first: got %h want 111111111", a_data);
        end
        a_val[0] = 12'h222; a_val[1] = 12'h222; a_val[2] = 12'h222;
        for (int i = 0; i < SP + 60; i++) begin
            step();
            if (a_overrun === 1'b1) begin
                ov++;
                ov_data = a_data;
                ov_valid = a_valid;
            end
        end
        checks++;
        if (ov != 1) begin
            errors++;
            $display("FAIL overrun_count: got %0d want 1", ov);
        end
        checks++;
        if (ov_data !== 36'h222222222 || ov_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_data: data %h valid %b want 222222222 1", ov_data, ov_valid);
        end
        a_ready = 1'b1;
        step();
        a_ready = 1'b0;
        checks++;
        if (a_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_clear: got %b want 0", a_valid);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        a_val[0] = 12'h5A5; a_val[1] = 12'h3C3; a_val[2] = 12'h0F0;
        wait_a_cs(1'b0, SP + 10, ok);
        a_pulses = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (a_pulses >= 8) break;
        end
        a_reset = 1'b0;
        step();
        checks++;
        if ({a_adc_cs, a_adc_clk, a_valid, a_busy} !== 4'b1100) begin
            errors++;
            $display("FAIL midframe_reset: cs/clk/valid/busy got %b want 1100",
                     {a_adc_cs, a_adc_clk, a_valid, a_busy});
        end
        a_reset = 1'b1;
        t_rel = cyc;
        wait_a_cs(1'b0, SP + 10, ok);
        checks++;
        if (!ok || (cyc - t_rel) != SP) begin
            errors++;
            $display("FAIL restart_time: got %0d want %0d", cyc - t_rel, SP);
        end
        wait_a_valid(200, ok);
        checks++;
        if (!ok || a_data !== 36'h0F03C35A5) begin
            errors++;
            $display("FAIL restart_data: got %h want 0f03c35a5", a_data);
        end
        a_ready = 1'b1;
        step();
        a_ready = 1'b0;
    endtask

    task automatic test_enable();
        bit ok;
        int n_valid = 0;
        int t_e;
        a_val[0] = 12'h777; a_val[1] = 12'h777; a_val[2] = 12'h777;
        wait_a_cs(1'b0, SP + 10, ok);
        repeat (50) step();
        a_enable = 1'b0;
        a_ready = 1'b1;
        a_cs_falls = 0;
        for (int i = 0; i < 3 * SP; i++) begin
            step();
            if (a_valid === 1'b1) n_valid++;
        end
        a_ready = 1'b0;
        checks++;
        if (a_cs_falls != 0) begin
            errors++;
            $display("FAIL disabled_starts: got %0d cs falls want 0", a_cs_falls);
        end
        checks++;
        if (n_valid != 1 || a_data !== 36'h777777777) begin
            errors++;
            $display("FAIL frame_finish: valid cycles %0d data %h want 1 777777777", n_valid, a_data);
        end
        a_enable = 1'b1;
        t_e = cyc;
        wait_a_cs(1'b0, SP, ok);
        checks++;
        if (!ok || (cyc - t_e) != 150) begin
            errors++;
            $display("FAIL tick_resume: got %0d cycles want 150", cyc - t_e);
        end
    endtask

    task automatic test_averaging();
        bit ok = 1'b0;
        b_seq[0] = 12'd100; b_seq[1] = 12'd101; b_seq[2] = 12'd102; b_seq[3] = 12'd104;
        b_reset = 1'b0; b_enable = 1'b1; b_ready = 1'b0;
        repeat (3) step();
        b_idx = 0;
        b_cs_falls = 0;
        b_reset = 1'b1;
        for (int i = 0; i < 5 * SP; i++) begin
            step();
            if (b_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || b_cs_falls != 4) begin
            errors++;
            $display("FAIL avg_count: first valid after %0d frames (ok=%0d) want 4", b_cs_falls, ok);
        end
        checks++;
        if (b_data !== 12'd101) begin
            errors++;
            $display("FAIL avg_data: got %0d want 101", b_data);
        end
        b_ready = 1'b1;
        step();
        b_ready = 1'b0;
        checks++;
        if (b_valid !== 1'b0) begin
            errors++;
            $display("FAIL avg_clear: got %b want 0", b_valid);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_packing();
        test_backpressure();
        test_reset_midframe();
        test_enable();
        test_averaging();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/adc_capture_multi.md
Name: adc_capture_multi

Overview:
- Parametrised successor to the single-channel serial ADC reader.
- Drives one shared adc_clk/adc_cs pair to CHANNELS ADCS7476-style converters, each with its own adc_sd line, on a programmable sample period.
- Optionally averages 2^AVG_LOG2 conversions per channel before output.
- Presents packed results to the SDFT front end on a valid/ready handshake, with overrun reporting.

Parameters:
CHANNELS, 1, number of converters sharing adc_clk/adc_cs (1..8)
ADC_BITS, 12, result bits per conversion
FRAME_BITS, 16, adc_clk cycles per conversion frame
LEAD_ZEROS, 4, leading bits discarded before the MSB; LEAD_ZEROS+ADC_BITS <= FRAME_BITS
CLK_DIV, 4, clk cycles per adc_clk half-period (>=1)
SAMPLE_PERIOD, 20000, clk cycles between conversion starts (1 kHz at 20 MHz)
QUIET, 2, adc_clk half-periods with cs high after each frame
AVG_LOG2, 0, log2 of conversions averaged per output (0 = no averaging)

Ports:
clk  input  1  system clock, 20 MHz
reset  input  1  synchronous, active-low reset
enable  input  1  sample tick counter runs only while high
adc_clk  output  1  serial clock to converters, idles high
adc_cs  output  1  active-low chip select, shared
adc_sd  input  CHANNELS  serial data, bit i from converter i
data  output  CHANNELS*ADC_BITS  channel i at [i*ADC_BITS +: ADC_BITS]
valid  output  1  data holds an unconsumed result
ready  input  1  consumer accepts when valid && ready
overrun  output  1  one-cycle pulse when an unconsumed result is overwritten
busy  output  1  high from CS_SETUP through CS_HOLD

Behaviour:
- Reset (reset==0 at a clk edge):
  - adc_cs=1, adc_clk=1, data=0, valid=0, overrun=0, busy=0.
  - Tick counter, bit counter, average counter and accumulators cleared; FSM to IDLE.
  - A reset mid-frame aborts the frame; cs rises on the same edge.
- Tick counter:
  - Counts 0..SAMPLE_PERIOD-1 while enable=1 and holds while enable=0.
  - Raises start for one cycle on the wrap to 0.
  - A start while the FSM is not IDLE is dropped; no queueing.
- FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, COMMIT.
  - IDLE -> CS_SETUP on start. adc_cs goes low on the same edge.
  - CS_SETUP lasts CLK_DIV cycles with adc_clk high, then goes to SHIFT.
  - SHIFT runs FRAME_BITS adc_clk periods. Each period is a falling half (adc_clk=0, CLK_DIV cycles) followed by a rising half (adc_clk=1, CLK_DIV cycles).
  - adc_sd is sampled on the clk edge that drives adc_clk 0->1.
  - Bit index k = 0..FRAME_BITS-1: k < LEAD_ZEROS discarded; the next ADC_BITS shift in MSB first; the remainder are discarded.
  - After the last rising half, go to CS_HOLD with adc_cs=1 for QUIET*CLK_DIV cycles, then COMMIT.
  - COMMIT (1 cycle): add each channel's shifted word into a (ADC_BITS+AVG_LOG2)-bit accumulator and increment the average counter.
    - If the counter reaches 2^AVG_LOG2: data_i = acc_i >> AVG_LOG2 (truncating), valid=1 on the next edge, accumulators and counter cleared.
    - Go to IDLE.
- Conversion duration: start-to-cs-rise = CLK_DIV*(1+2*FRAME_BITS) cycles. The result latency from cs rise is QUIET*CLK_DIV+1 cycles.
- Handshake:
  - valid stays high, and data stays stable, until a cycle with ready=1.
  - valid falls on the edge after that transfer.
  - If COMMIT produces a result in the same cycle as a transfer, the new result loads and valid stays 1; no overrun.
  - If COMMIT produces a result while valid=1 and ready=0, data is overwritten, valid stays 1, and overrun pulses for 1 cycle.
- enable=0 mid-frame: the frame completes normally; only new starts stop.
- Configuration constraint: SAMPLE_PERIOD must exceed the conversion duration plus QUIET*CLK_DIV+1. This is checked by a simulation-only assertion.

Test Plan:
- Nominal capture: CHANNELS=1, AVG_LOG2=0, CLK_DIV=4, model drives 0x0ABC -> valid after 4*33+8+1=141 cycles from start, data=0xABC, adc_clk exactly 16 low pulses while cs low.
- Multi-channel packing: CHANNELS=3, models drive 0x001, 0x800, 0xFFF -> data=0xFFF_800_001.
- Averaging: AVG_LOG2=2, successive conversions 100, 101, 102, 104 -> one valid result with data=101 (407>>2) and no valid in between.
- Backpressure and overrun: ready held 0 across two results 0x111 then 0x222 -> overrun pulses once at the second COMMIT, data=0x222; ready=1 then clears valid the next cycle.
- Reset mid-frame: assert reset at bit 7 of SHIFT -> adc_cs=1, adc_clk=1, valid=0 next edge; after release, the first result appears one full SAMPLE_PERIOD later and is correct.
- Enable gating: enable=0 for 3 periods -> zero cs falls; when re-enabled, the tick counter resumes from its held value.
